// File: rtl/sregs_arb_pkg.sv
// Shared definitions for the sclk-domain register-bank access arbiter.
//   arb_state_e : access sequencer states (idle, strobe issue, read wait, ack)
//   OOR_RDATA   : data returned for reads of unimplemented registers
//   SRC_HOST    : source index reserved for the host stream
package sregs_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StAck   = 2'd3
  } arb_state_e;

  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;
  localparam int unsigned SRC_HOST  = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req       : request vector, one bit per source
//   ptr       : highest-priority source index for this decision
//   gnt       : one-hot grant (all zero when nothing requests)
//   gnt_idx   : encoded index of the granted source
//   gnt_valid : at least one source requested
module rr_arbiter #(
  parameter  int unsigned N    = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx,
  output logic            gnt_valid
);

  always_comb begin
    int unsigned idx;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    // Walk the sources starting at ptr, wrapping; the first requester wins.
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr) + off) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/sregs_access_arbiter.sv
// Sequences every access to the sclk-domain SATA register bank. The host stream (source 0)
// and N_INT internal requesters (sources 1..N_INT) share one bank port; a round-robin
// pointer picks the winner and exactly one access is in flight at a time.
//   sclk, rst                     : clock, synchronous active-high reset
//   host_val/rd/addr/wdata        : host request from the write FIFO
//   host_ack, host_rdata          : host done strobe (pops FIFO), host read data
//   int_req/we/addr/wdata         : packed internal requests, held until int_ack
//   int_ack, int_rdata            : one-hot internal done strobe, shared read data
//   reg_addr/wdata/we/re, reg_rdata : register bank port
module sregs_access_arbiter
  import sregs_arb_pkg::*;
#(
  parameter int unsigned SREGS_ADDR_BITS = 4,
  parameter int unsigned REG_COUNT       = 16,
  parameter int unsigned N_INT           = 2,
  parameter int unsigned RD_LATENCY      = 1
) (
  input  logic                         sclk,
  input  logic                         rst,
  input  logic                         host_val,
  input  logic                         host_rd,
  input  logic [SREGS_ADDR_BITS-1:0]   host_addr,
  input  logic [31:0]                  host_wdata,
  output logic                         host_ack,
  output logic [31:0]                  host_rdata,
  input  logic [N_INT-1:0]             int_req,
  input  logic [N_INT-1:0]             int_we,
  input  logic [N_INT*SREGS_ADDR_BITS-1:0] int_addr,
  input  logic [N_INT*32-1:0]          int_wdata,
  output logic [N_INT-1:0]             int_ack,
  output logic [31:0]                  int_rdata,
  output logic [SREGS_ADDR_BITS-1:0]   reg_addr,
  output logic [31:0]                  reg_wdata,
  output logic                         reg_we,
  output logic                         reg_re,
  input  logic [31:0]                  reg_rdata
);

  localparam int unsigned NSrc = N_INT + 1;
  localparam int unsigned SrcW = $clog2(NSrc);
  localparam int unsigned AW   = SREGS_ADDR_BITS;

  arb_state_e           state_q, state_d;
  logic [SrcW-1:0]      ptr_q, ptr_d;
  logic [SrcW-1:0]      src_q, src_d;
  logic                 rd_q, rd_d;
  logic                 oor_q, oor_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 guard_q, guard_d;
  logic                 reg_we_q, reg_we_d;
  logic                 reg_re_q, reg_re_d;
  logic                 host_ack_q, host_ack_d;
  logic [N_INT-1:0]     int_ack_q, int_ack_d;
  logic [31:0]          host_rdata_q, host_rdata_d;
  logic [31:0]          int_rdata_q, int_rdata_d;

  logic [NSrc-1:0]      eligible;
  logic [NSrc-1:0]      gnt;
  logic [SrcW-1:0]      gnt_idx;
  logic                 gnt_valid;
  logic                 sel_rd;
  logic [AW-1:0]        sel_addr;
  logic [31:0]          sel_wdata;
  logic                 sel_oor;
  logic [31:0]          cap_data;
  logic                 ack_now;

  // The guard hides the host for one IDLE cycle after its ack, while the FIFO's empty
  // flag catches up with the pop.
  assign eligible = {int_req, host_val & ~guard_q};

  rr_arbiter #(
    .N (NSrc)
  ) u_rr (
    .req       (eligible),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Request fields of the current winner.
  always_comb begin
    sel_rd    = host_rd;
    sel_addr  = host_addr;
    sel_wdata = host_wdata;
    for (int unsigned i = 0; i < N_INT; i++) begin
      if (gnt_idx == SrcW'(i + 1)) begin
        sel_rd    = ~int_we[i];
        sel_addr  = int_addr[i*AW +: AW];
        sel_wdata = int_wdata[i*32 +: 32];
      end
    end
  end

  assign sel_oor  = (32'(sel_addr) >= REG_COUNT);
  assign cap_data = oor_q ? OOR_RDATA : reg_rdata;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    src_d        = src_q;
    rd_d         = rd_q;
    oor_d        = oor_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    guard_d      = guard_q;
    host_rdata_d = host_rdata_q;
    int_rdata_d  = int_rdata_q;
    reg_we_d     = 1'b0;
    reg_re_d     = 1'b0;
    host_ack_d   = 1'b0;
    int_ack_d    = '0;
    ack_now      = 1'b0;

    unique case (state_q)
      StIdle: begin
        guard_d = 1'b0;
        if (gnt_valid) begin
          src_d    = gnt_idx;
          rd_d     = sel_rd;
          oor_d    = sel_oor;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          ptr_d    = (32'(gnt_idx) == NSrc - 1) ? '0 : gnt_idx + SrcW'(1);
          // Strobes are registered so they appear in the ISSUE cycle.
          reg_we_d = ~sel_rd & ~sel_oor;
          reg_re_d = sel_rd & ~sel_oor;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (rd_q) begin
          cnt_d   = 2'(RD_LATENCY - 1);
          state_d = StWait;
        end else begin
          ack_now = 1'b1;
          state_d = StAck;
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) begin
          if (src_q == SrcW'(SRC_HOST)) host_rdata_d = cap_data;
          else                          int_rdata_d  = cap_data;
          ack_now = 1'b1;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StAck: begin
        guard_d = (src_q == SrcW'(SRC_HOST));
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Ack flops are loaded on entry to ACK so the strobe lasts exactly the ACK cycle.
    if (ack_now) begin
      host_ack_d = (src_q == SrcW'(SRC_HOST));
      for (int unsigned i = 0; i < N_INT; i++) begin
        int_ack_d[i] = (src_q == SrcW'(i + 1));
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      src_q        <= '0;
      rd_q         <= 1'b0;
      oor_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      guard_q      <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_re_q     <= 1'b0;
      host_ack_q   <= 1'b0;
      int_ack_q    <= '0;
      host_rdata_q <= '0;
      int_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      src_q        <= src_d;
      rd_q         <= rd_d;
      oor_q        <= oor_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      guard_q      <= guard_d;
      reg_we_q     <= reg_we_d;
      reg_re_q     <= reg_re_d;
      host_ack_q   <= host_ack_d;
      int_ack_q    <= int_ack_d;
      host_rdata_q <= host_rdata_d;
      int_rdata_q  <= int_rdata_d;
    end
  end

  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign int_ack    = int_ack_q;
  assign int_rdata  = int_rdata_q;
  assign reg_addr   = addr_q;
  assign reg_wdata  = wdata_q;
  assign reg_we     = reg_we_q;
  assign reg_re     = reg_re_q;

endmodule
